mem_stage: RTL

//  Consumer side of the EX->MEM pipeline boundary. Takes the registered EX results, runs data-memory

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_branch_unit.sv | 32 +++
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants, types and helpers for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FLAG_W      = 6;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned FLAG_ADDR_W = 5;
  localparam int unsigned WB_MUX_W    = 2;
  localparam int unsigned FLAG_IDX_W  = 3;

  localparam logic [WB_MUX_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_MUX_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_MUX_W-1:0] WB_PC  = 2'd2;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_LT    = 3;
  localparam int unsigned FLAG_GT    = 4;
  localparam int unsigned FLAG_CARRY = 5;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_e;

  // Write-back payload of a memory instruction parked while its access is in flight.
  typedef struct packed {
    logic                  is_store;
    logic                  reg_write_enable;
    logic                  fl_write_enable;
    logic [FLAG_W-1:0]     alu_flags;
    logic [WB_MUX_W-1:0]   wb_res_mux;
    logic [REG_ADDR_W-1:0] reg_dst;
    logic [DATA_W-1:0]     alu_out;
  } pend_t;

  // Only the low three address bits select a flag; indices past the top flag fall back to flag 0.
  function automatic logic [FLAG_IDX_W-1:0] flag_index(input logic [FLAG_ADDR_W-1:0] addr);
    logic [FLAG_IDX_W-1:0] lo;
    lo = FLAG_IDX_W'(addr);
    return (lo > FLAG_IDX_W'(FLAG_W - 1)) ? '0 : lo;
  endfunction

endpackage

// File: rtl/mem_stage_branch_unit.sv
// Combinational branch/jump resolution: taken decision and redirect target.
module branch_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic [FLAG_W-1:0]      flags_q,
  input  logic                   alu_zero,
  input  logic                   sel_beq_bne,
  input  logic                   sel_jt_jf,
  input  logic                   sel_jflag_branch,
  input  logic                   is_branch,
  input  logic                   is_jump,
  input  logic [FLAG_ADDR_W-1:0] flag_addr,
  input  logic [PC_WIDTH-1:0]    next_pc,
  input  logic [DATA_W-1:0]      immediate,
  input  logic [DATA_W-1:0]      abs_addr,
  output logic                   taken_c,
  output logic [PC_WIDTH-1:0]    target_c
);

  logic flag_bit;
  logic cond;

  always_comb begin
    flag_bit = flags_q[flag_index(flag_addr)];
    cond     = sel_jflag_branch ? (flag_bit ^ sel_jt_jf) : (alu_zero ^ sel_beq_bne);
    taken_c  = is_branch ? cond : is_jump;
    target_c = is_jump ? PC_WIDTH'(abs_addr) : next_pc + PC_WIDTH'(immediate);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM, flag register, branch resolution and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_mem_write_enable,
  input  logic                   in_sel_beq_bne,
  input  logic                   in_fl_write_enable,
  input  logic                   in_sel_jt_jf,
  input  logic                   in_sel_jflag_branch,
  input  logic                   in_is_branch,
  input  logic                   in_is_jump,
  input  logic [WB_MUX_W-1:0]    in_wb_res_mux,
  input  logic                   in_reg_write_enable,
  input  logic [PC_WIDTH-1:0]    in_next_pc,
  input  logic [DATA_W-1:0]      in_immediate,
  input  logic [DATA_W-1:0]      in_abs_addr,
  input  logic [DATA_W-1:0]      in_mem_addr,
  input  logic [DATA_W-1:0]      in_mem_data,
  input  logic [DATA_W-1:0]      in_alu_out,
  input  logic [FLAG_W-1:0]      in_alu_flags,
  input  logic [FLAG_ADDR_W-1:0] in_flag_addr,
  input  logic [REG_ADDR_W-1:0]  in_reg_dst,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_W-1:0]      dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic [DATA_W-1:0]      dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   stall,
  output logic                   redirect,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   mem_err,
  output logic [FLAG_W-1:0]      flags_q,
  output logic                   wb_valid,
  output logic                   wb_reg_write_enable,
  output logic [WB_MUX_W-1:0]    wb_wb_res_mux,
  output logic [REG_ADDR_W-1:0]  wb_reg_dst,
  output logic [DATA_W-1:0]      wb_alu_out,
  output logic [DATA_W-1:0]      wb_mem_rdata,
  output logic [PC_WIDTH-1:0]    wb_next_pc
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  pend_t               pend_q;
  logic [PC_WIDTH-1:0] pend_next_pc_q;

  logic                is_mem_c;
  logic                issue_c;
  logic                retire_in_c;
  logic                retire_mem_c;
  logic                timeout_c;
  logic                taken_c;
  logic [PC_WIDTH-1:0] target_c;

  branch_unit #(.PC_WIDTH(PC_WIDTH)) u_branch (
    .flags_q          (flags_q),
    .alu_zero         (in_alu_flags[FLAG_ZERO]),
    .sel_beq_bne      (in_sel_beq_bne),
    .sel_jt_jf        (in_sel_jt_jf),
    .sel_jflag_branch (in_sel_jflag_branch),
    .is_branch        (in_is_branch),
    .is_jump          (in_is_jump),
    .flag_addr        (in_flag_addr),
    .next_pc          (in_next_pc),
    .immediate        (in_immediate),
    .abs_addr         (in_abs_addr),
    .taken_c          (taken_c),
    .target_c         (target_c)
  );

  assign is_mem_c = (in_mem_write_enable || (in_wb_res_mux == WB_MEM))
                    && !(in_is_branch || in_is_jump);

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d      = state_q;
    issue_c      = 1'b0;
    retire_in_c  = 1'b0;
    retire_mem_c = 1'b0;
    timeout_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mem_c) begin
            issue_c = 1'b1;
            state_d = S_WAIT_ACK;
          end else begin
            retire_in_c = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        if (dmem_ack) begin
          retire_mem_c = 1'b1;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          timeout_c    = 1'b1;
          retire_mem_c = 1'b1;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request side: counter, held request fields and parked write-back payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      pend_q         <= '0;
      pend_next_pc_q <= '0;
      stall          <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      stall <= (state_d == S_WAIT_ACK);
      if (issue_c) begin
        cnt_q          <= '0;
        dmem_req       <= 1'b1;
        dmem_we        <= in_mem_write_enable;
        dmem_addr      <= in_mem_addr;
        dmem_wdata     <= in_mem_data;
        pend_q         <= '{is_store:         in_mem_write_enable,
                            reg_write_enable: in_reg_write_enable,
                            fl_write_enable:  in_fl_write_enable,
                            alu_flags:        in_alu_flags,
                            wb_res_mux:       in_wb_res_mux,
                            reg_dst:          in_reg_dst,
                            alu_out:          in_alu_out};
        pend_next_pc_q <= in_next_pc;
      end else if (retire_mem_c) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end else if (state_q == S_WAIT_ACK) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_c) mem_err <= 1'b1;
    end
  end

  // Retire side: MEM/WB register, flag register and redirect pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid            <= 1'b0;
      wb_reg_write_enable <= 1'b0;
      wb_wb_res_mux       <= '0;
      wb_reg_dst          <= '0;
      wb_alu_out          <= '0;
      wb_mem_rdata        <= '0;
      wb_next_pc          <= '0;
      flags_q             <= '0;
      redirect            <= 1'b0;
      redirect_pc         <= '0;
    end else begin
      wb_valid            <= retire_in_c || retire_mem_c;
      wb_reg_write_enable <= 1'b0;
      redirect            <= retire_in_c && taken_c;
      if (retire_in_c) begin
        wb_reg_write_enable <= in_reg_write_enable;
        wb_wb_res_mux       <= in_wb_res_mux;
        wb_reg_dst          <= in_reg_dst;
        wb_alu_out          <= in_alu_out;
        wb_next_pc          <= in_next_pc;
        if (in_fl_write_enable) flags_q <= in_alu_flags;
        if (taken_c) redirect_pc <= target_c;
      end
      if (retire_mem_c) begin
        wb_reg_write_enable <= pend_q.reg_write_enable && !pend_q.is_store && !timeout_c;
        wb_wb_res_mux       <= pend_q.wb_res_mux;
        wb_reg_dst          <= pend_q.reg_dst;
        wb_alu_out          <= pend_q.alu_out;
        wb_next_pc          <= pend_next_pc_q;
        if (!timeout_c) wb_mem_rdata <= dmem_rdata;
        if (pend_q.fl_write_enable) flags_q <= pend_q.alu_flags;
      end
    end
  end

endmodule
